// File: rtl/ahb_slave_if_if.sv
// Bundle of AHB slave-side bus signals and the simple backend handshake.
// Modports:
//   slave  - the AHB slave converter (ahb_slave_if) view
//   master - the view of whatever drives the bus and models the backend
interface ahb_slave_if_if #(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = AHB_DATA_WIDTH / 8;

  // AHB address/data phase
  logic                      ahb_sel_in;
  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in;
  logic [1:0]                ahb_trans_in;
  logic                      ahb_write_in;
  logic [2:0]                ahb_size_in;
  logic [2:0]                ahb_burst_in;
  logic [3:0]                ahb_prot_in;
  logic [STRB_W-1:0]         ahb_strb_in;
  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in;
  logic                      ahb_ready_in;
  logic                      ahb_readyout_out;
  logic                      ahb_resp_out;
  logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out;

  // Backend request/response
  logic                      other_valid_out;
  logic                      other_write_out;
  logic [AHB_ADDR_WIDTH-1:0] other_addr_out;
  logic [3:0]                other_prot_out;
  logic [STRB_W-1:0]         other_strb_out;
  logic [AHB_DATA_WIDTH-1:0] other_wdata_out;
  logic                      other_ready_in;
  logic [AHB_DATA_WIDTH-1:0] other_rdata_in;
  logic                      other_error_in;

  modport slave (
    input  ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_write_in, ahb_size_in,
           ahb_burst_in, ahb_prot_in, ahb_strb_in, ahb_wdata_in, ahb_ready_in,
           other_ready_in, other_rdata_in, other_error_in,
    output ahb_readyout_out, ahb_resp_out, ahb_rdata_out,
           other_valid_out, other_write_out, other_addr_out, other_prot_out,
           other_strb_out, other_wdata_out
  );

  modport master (
    output ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_write_in, ahb_size_in,
           ahb_burst_in, ahb_prot_in, ahb_strb_in, ahb_wdata_in, ahb_ready_in,
           other_ready_in, other_rdata_in, other_error_in,
    input  ahb_readyout_out, ahb_resp_out, ahb_rdata_out,
           other_valid_out, other_write_out, other_addr_out, other_prot_out,
           other_strb_out, other_wdata_out
  );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB slave converter: turns AHB address/data-phase transfers into a
// one-request-at-a-time backend handshake, inserting wait states while the
// backend is busy and producing the two-cycle ERROR response for failed
// checks, backend errors and backend timeouts.
// Ports:
//   ahb_clk_in   - bus clock, rising edge
//   ahb_rstn_in  - asynchronous active-low reset
//   bus          - ahb_slave_if_if.slave: AHB signals + backend handshake
//                  (readyout/resp/rdata/wdata/strb are combinational,
//                  all other outputs registered)
module ahb_slave_if #(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned WAIT_TIMEOUT   = 16
) (
  input  logic          ahb_clk_in,
  input  logic          ahb_rstn_in,
  ahb_slave_if_if.slave bus
);

  localparam int unsigned STRB_W = AHB_DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(STRB_W);
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ERR1   = 2'd2;
  localparam logic [1:0] ST_ERR2   = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      valid_q, valid_d;
  logic                      write_q, write_d;
  logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]                prot_q, prot_d;
  logic [STRB_W-1:0]         mask_q, mask_d;

  logic                      accept_c;
  logic                      size_ok_c;
  logic                      aligned_c;
  logic                      take_c;
  logic                      readyout_c;
  logic                      resp_c;
  logic [AHB_DATA_WIDTH-1:0] rdata_c;
  logic                      unused_c;

  // Byte lanes covered by a transfer of 1<<size bytes at lane offset off
  function automatic logic [STRB_W-1:0] lane_mask(input logic [2:0] size,
                                                  input logic [LANE_W-1:0] off);
    logic [STRB_W-1:0] m;
    int unsigned       o;
    int unsigned       bytes;
    o     = 32'(off);
    bytes = 32'd1 << size;
    m     = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      m[i] = (i >= o) && (i < o + bytes);
    end
    return m;
  endfunction

  // Address-phase qualification and transfer checks
  assign accept_c  = bus.ahb_sel_in && bus.ahb_ready_in && bus.ahb_trans_in[1];
  assign size_ok_c = (32'd8 << bus.ahb_size_in) <= AHB_DATA_WIDTH;
  assign aligned_c = (bus.ahb_addr_in &
                      AHB_ADDR_WIDTH'((32'd1 << bus.ahb_size_in) - 32'd1)) == '0;

  // Next-state and response logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    prot_d     = prot_q;
    mask_d     = mask_q;
    readyout_c = 1'b1;
    resp_c     = 1'b0;
    rdata_c    = '0;
    take_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        take_c = 1'b1;
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.other_ready_in && !bus.other_error_in) begin
          take_c  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!write_q) rdata_c = bus.other_rdata_in;
        end else if (bus.other_ready_in || (cnt_q == CNT_LAST)) begin
          // Backend error or timeout: first ERROR cycle
          readyout_c = 1'b0;
          resp_c     = 1'b1;
          state_d    = ST_ERR2;
          cnt_d      = '0;
        end else begin
          readyout_c = 1'b0;
        end
      end
      ST_ERR1: begin
        readyout_c = 1'b0;
        resp_c     = 1'b1;
        state_d    = ST_ERR2;
      end
      default: begin // ST_ERR2
        resp_c  = 1'b1;
        take_c  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // New address phase, only in cycles where this slave completes
    if (take_c && accept_c) begin
      state_d = (size_ok_c && aligned_c) ? ST_ACCESS : ST_ERR1;
      cnt_d   = '0;
      write_d = bus.ahb_write_in;
      addr_d  = bus.ahb_addr_in;
      prot_d  = bus.ahb_prot_in;
      mask_d  = lane_mask(bus.ahb_size_in, bus.ahb_addr_in[LANE_W-1:0]);
    end

    valid_d = (state_d == ST_ACCESS);
  end

  // State and captured request registers
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      prot_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      prot_q  <= prot_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.ahb_readyout_out = readyout_c;
  assign bus.ahb_resp_out     = resp_c;
  assign bus.ahb_rdata_out    = rdata_c;
  assign bus.other_valid_out  = valid_q;
  assign bus.other_write_out  = write_q;
  assign bus.other_addr_out   = addr_q;
  assign bus.other_prot_out   = prot_q;
  assign bus.other_wdata_out  = bus.ahb_wdata_in;
  assign bus.other_strb_out   = write_q ? (mask_q & bus.ahb_strb_in) : mask_q;

  // HBURST and HTRANS[0] carry no meaning for this slave
  assign unused_c = ^{bus.ahb_burst_in, bus.ahb_trans_in[0]};

endmodule

// File: tb/tb_ahb_slave_if.sv
module tb_ahb_slave_if;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;

  ahb_slave_if_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32)) bus ();

  ahb_slave_if #(
    .AHB_ADDR_WIDTH(32),
    .AHB_DATA_WIDTH(32),
    .WAIT_TIMEOUT  (4)
  ) dut (
    .ahb_clk_in (clk),
    .ahb_rstn_in(rstn),
    .bus        (bus)
  );

  // Single slave on the bus: HREADY is this slave's HREADYOUT
  assign bus.ahb_ready_in = bus.ahb_readyout_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [1:0] trans, input logic wr,
                            input logic [2:0] size, input logic [31:0] addr);
    bus.ahb_sel_in   = 1'b1;
    bus.ahb_trans_in = trans;
    bus.ahb_write_in = wr;
    bus.ahb_size_in  = size;
    bus.ahb_addr_in  = addr;
  endtask

  task automatic bus_idle();
    bus.ahb_sel_in   = 1'b0;
    bus.ahb_trans_in = 2'd0;
  endtask

  // Drive at the falling edge, check 1 time unit later
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic resp(input string tag, input logic ro, input logic rs, input logic v);
    chk({tag, "_readyout"}, 64'(bus.ahb_readyout_out), 64'(ro));
    chk({tag, "_resp"},     64'(bus.ahb_resp_out),     64'(rs));
    chk({tag, "_valid"},    64'(bus.other_valid_out),  64'(v));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstn  = 1'b0;
    bus.ahb_sel_in     = 1'b0;
    bus.ahb_addr_in    = '0;
    bus.ahb_trans_in   = 2'd0;
    bus.ahb_write_in   = 1'b0;
    bus.ahb_size_in    = 3'd0;
    bus.ahb_burst_in   = 3'd0;
    bus.ahb_prot_in    = 4'h0;
    bus.ahb_strb_in    = '0;
    bus.ahb_wdata_in   = '0;
    bus.other_ready_in = 1'b0;
    bus.other_rdata_in = '0;
    bus.other_error_in = 1'b0;

    // Reset values
    #3;
    resp("rst", 1'b1, 1'b0, 1'b0);
    chk("rst_rdata", 64'(bus.ahb_rdata_out),   64'h0);
    chk("rst_write", 64'(bus.other_write_out), 64'h0);
    chk("rst_addr",  64'(bus.other_addr_out),  64'h0);
    chk("rst_prot",  64'(bus.other_prot_out),  64'h0);
    chk("rst_strb",  64'(bus.other_strb_out),  64'h0);
    cyc();
    rstn = 1'b1;

    // Zero-wait write 0x1000 size 2
    cyc();
    addr_phase(2'd2, 1'b1, 3'd2, 32'h1000);
    bus.ahb_prot_in = 4'h3;
    #1 resp("wr_ap", 1'b1, 1'b0, 1'b0);
    cyc();
    bus_idle();
    bus.ahb_wdata_in   = 32'hDEADBEEF;
    bus.ahb_strb_in    = 4'hF;
    bus.other_ready_in = 1'b1;
    #1 resp("wr_dp", 1'b1, 1'b0, 1'b1);
    chk("wr_strb",  64'(bus.other_strb_out),  64'hF);
    chk("wr_wdata", 64'(bus.other_wdata_out), 64'hDEADBEEF);
    chk("wr_addr",  64'(bus.other_addr_out),  64'h1000);
    chk("wr_write", 64'(bus.other_write_out), 64'h1);
    chk("wr_prot",  64'(bus.other_prot_out),  64'h3);

    // Read 0x2002 size 1, backend answers in the 4th data-phase cycle
    cyc();
    bus.other_ready_in = 1'b0;
    addr_phase(2'd2, 1'b0, 3'd1, 32'h2002);
    #1 resp("wr_done", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus_idle();
      #1 resp($sformatf("rd_wait%0d", i), 1'b0, 1'b0, 1'b1);
      chk($sformatf("rd_wait%0d_rdata", i), 64'(bus.ahb_rdata_out), 64'h0);
    end
    cyc();
    bus.other_ready_in = 1'b1;
    bus.other_rdata_in = 32'h12345678;
    #1 resp("rd_done", 1'b1, 1'b0, 1'b1);
    chk("rd_rdata", 64'(bus.ahb_rdata_out),  64'h12345678);
    chk("rd_strb",  64'(bus.other_strb_out), 64'hC);

    // Backend ready ignored in IDLE; misaligned read 0x1001 size 2
    cyc();
    addr_phase(2'd2, 1'b0, 3'd2, 32'h1001);
    #1 resp("idle_ign", 1'b1, 1'b0, 1'b0);
    chk("idle_rdata", 64'(bus.ahb_rdata_out), 64'h0);
    cyc();
    bus_idle();
    bus.other_ready_in = 1'b0;
    #1 resp("mis_e1", 1'b0, 1'b1, 1'b0);
    cyc();
    // Oversized (size 3 on 32-bit data) accepted during ERR2
    addr_phase(2'd2, 1'b0, 3'd3, 32'h3000);
    #1 resp("mis_e2", 1'b1, 1'b1, 1'b0);
    cyc();
    bus_idle();
    #1 resp("big_e1", 1'b0, 1'b1, 1'b0);
    cyc();
    #1 resp("big_e2", 1'b1, 1'b1, 1'b0);

    // Backend error on write, then NONSEQ read accepted in ERR2
    cyc();
    addr_phase(2'd2, 1'b1, 3'd2, 32'h40);
    #1 resp("be_ap", 1'b1, 1'b0, 1'b0);
    cyc();
    bus_idle();
    bus.ahb_strb_in    = 4'h5;
    bus.other_ready_in = 1'b1;
    bus.other_error_in = 1'b1;
    #1 resp("be_e1", 1'b0, 1'b1, 1'b1);
    chk("be_strb", 64'(bus.other_strb_out), 64'h5);
    cyc();
    bus.other_ready_in = 1'b0;
    bus.other_error_in = 1'b0;
    addr_phase(2'd2, 1'b0, 3'd2, 32'h44);
    #1 resp("be_e2", 1'b1, 1'b1, 1'b0);
    cyc();
    bus_idle();
    bus.other_ready_in = 1'b1;
    bus.other_rdata_in = 32'hCAFEF00D;
    #1 resp("be_next", 1'b1, 1'b0, 1'b1);
    chk("be_next_addr",  64'(bus.other_addr_out),  64'h44);
    chk("be_next_write", 64'(bus.other_write_out), 64'h0);
    chk("be_next_rdata", 64'(bus.ahb_rdata_out),   64'hCAFEF00D);

    // Timeout with WAIT_TIMEOUT=4: 3 waits, ERROR pair, valid drops
    cyc();
    bus.other_ready_in = 1'b0;
    addr_phase(2'd2, 1'b0, 3'd2, 32'h80);
    #1 resp("to_ap", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus_idle();
      #1 resp($sformatf("to_wait%0d", i), 1'b0, 1'b0, 1'b1);
    end
    cyc();
    #1 resp("to_e1", 1'b0, 1'b1, 1'b1);
    cyc();
    #1 resp("to_e2", 1'b1, 1'b1, 1'b0);
    cyc();
    #1 resp("to_idle", 1'b1, 1'b0, 1'b0);

    // Pipelined reads 0x100.. with zero-wait backend
    cyc();
    bus.other_ready_in = 1'b1;
    addr_phase(2'd2, 1'b0, 3'd2, 32'h100);
    #1 resp("pl_ap", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      addr_phase(2'd3, 1'b0, 3'd2, 32'h104 + 32'(4 * i));
      bus.other_rdata_in = 32'hA000_0000 + 32'(i);
      #1 resp($sformatf("pl%0d", i), 1'b1, 1'b0, 1'b1);
      chk($sformatf("pl%0d_addr", i),  64'(bus.other_addr_out), 64'(32'h100 + 32'(4 * i)));
      chk($sformatf("pl%0d_rdata", i), 64'(bus.ahb_rdata_out),  64'(32'hA000_0000 + 32'(i)));
    end

    // Reset mid-burst: outputs return to reset values immediately
    cyc();
    rstn = 1'b0;
    #1 resp("mrst", 1'b1, 1'b0, 1'b0);
    chk("mrst_rdata", 64'(bus.ahb_rdata_out),   64'h0);
    chk("mrst_addr",  64'(bus.other_addr_out),  64'h0);
    chk("mrst_strb",  64'(bus.other_strb_out),  64'h0);
    chk("mrst_write", 64'(bus.other_write_out), 64'h0);
    chk("mrst_prot",  64'(bus.other_prot_out),  64'h0);

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
# ahb_slave_if

AHB slave interface that sits directly downstream of `ahb_master_if` across the AHB bus (via the decoder/mux) and converts AHB address/data-phase transfers into a simple one-request-at-a-time backend handshake for a register file or memory. It checks transfers, inserts wait states while the backend is busy, and generates the two-cycle ERROR response. It also generates an ERROR response when the backend does not answer within a bounded number of cycles.

## Interface
- `AHB_ADDR_WIDTH`, 32, address width
- `AHB_DATA_WIDTH`, 32, data width (32/64/128 supported)
- `WAIT_TIMEOUT`, 16, maximum data-phase wait cycles before a forced ERROR (1..255)

Ports:
- `ahb_clk_in`  in  1  bus clock; all logic on rising edge
- `ahb_rstn_in`  in  1  asynchronous, active-low reset
- `ahb_sel_in`  in  1  slave select from decoder
- `ahb_addr_in`  in  AHB_ADDR_WIDTH  address-phase address
- `ahb_trans_in`  in  2  HTRANS: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- `ahb_write_in`  in  1  1 = write
- `ahb_size_in`  in  3  HSIZE; transfer bytes = 1<<size
- `ahb_burst_in`  in  3  HBURST; informational, not checked
- `ahb_prot_in`  in  4  HPROT, forwarded
- `ahb_strb_in`  in  AHB_DATA_WIDTH/8  data-phase write strobes
- `ahb_wdata_in`  in  AHB_DATA_WIDTH  data-phase write data
- `ahb_ready_in`  in  1  bus HREADY (shared)
- `ahb_readyout_out`  out  1  slave HREADYOUT
- `ahb_resp_out`  out  1  0 OKAY, 1 ERROR
- `ahb_rdata_out`  out  AHB_DATA_WIDTH  read data
- `other_valid_out`  out  1  backend request valid
- `other_write_out`  out  1  backend write
- `other_addr_out`  out  AHB_ADDR_WIDTH  backend address
- `other_prot_out`  out  4  captured HPROT
- `other_strb_out`  out  AHB_DATA_WIDTH/8  byte-lane enables
- `other_wdata_out`  out  AHB_DATA_WIDTH  write data (= `ahb_wdata_in`)
- `other_ready_in`  in  1  backend completes current request
- `other_rdata_in`  in  AHB_DATA_WIDTH  backend read data, valid with `other_ready_in`
- `other_error_in`  in  1  backend error, valid with `other_ready_in`

## Operation
- Address phase accepted at a rising edge when `ahb_sel_in && ahb_ready_in && ahb_trans_in[1]`. IDLE/BUSY or unselected transfers are not accepted and get zero-wait OKAY.
- Checks at acceptance: size_ok = (8<<size) <= AHB_DATA_WIDTH; aligned = addr & ((1<<size)-1) == 0. A transfer that fails either check does not reach the backend.
- Lane mask = ((1<<(1<<size))-1) << addr[log2(AHB_DATA_WIDTH/8)-1:0], registered at acceptance. `other_strb_out` = mask & `ahb_strb_in` for writes, mask for reads.
- States:
  - ST_IDLE: `readyout`=1, `resp`=0. Valid acceptance → ST_ACCESS; failed check → ST_ERR1.
  - ST_ACCESS: `other_valid_out`=1, wait counter increments.
    - `other_ready_in && !other_error_in`: `readyout`=1, `resp`=0; reads drive `ahb_rdata_out`=`other_rdata_in`. Next state is ST_ACCESS/ST_ERR1 if a new transfer is accepted in the same cycle (pipelined), else ST_IDLE.
    - `other_ready_in && other_error_in`: `readyout`=0, `resp`=1 → ST_ERR2.
    - Counter reaching WAIT_TIMEOUT-1 without ready: same as a backend error; `other_valid_out` drops and the counter clears.
    - Otherwise: `readyout`=0 (wait state).
  - ST_ERR1: `readyout`=0, `resp`=1 → ST_ERR2.
  - ST_ERR2: `readyout`=1, `resp`=1. A transfer accepted here is processed normally (→ ST_ACCESS/ST_ERR1), else → ST_IDLE.
- `ahb_rdata_out` = 0 except in a completing OKAY read cycle.
- `other_addr_out`, `other_write_out`, `other_prot_out` and the lane mask are registered at acceptance and held until the next acceptance.

## Timing
- Reset (async, immediate):
  - state ST_IDLE, counter 0
  - `ahb_readyout_out`=1, `ahb_resp_out`=0, `ahb_rdata_out`=0
  - `other_valid_out`=0, `other_write_out`=0, `other_addr_out`=0, `other_prot_out`=0, `other_strb_out`=0
- Reset mid-transfer: the request is abandoned with no response; the master is also reset.
- Request latency: `other_valid_out` rises in the cycle after acceptance (data phase).
- Zero-wait: backend ready in the first data-phase cycle gives `readyout`=1 in that same cycle.
- Back-to-back transfers sustain 1 transfer/cycle with a zero-wait backend.
- `readyout`, `resp`, `rdata`, `other_wdata_out` and `other_strb_out` are combinational from state and backend/bus inputs. All other outputs are registered.
- ERROR is always exactly 2 cycles: (resp=1, readyout=0) then (resp=1, readyout=1).
- `other_ready_in` outside ST_ACCESS is ignored.

## Test plan
- Write 0x1000, size 2, wdata 0xDEADBEEF, backend ready immediately → `other_valid_out` one cycle, `other_strb_out`=4'hF, `readyout`=1, `resp`=0; no wait state.
- Read 0x2002, size 1, backend ready after 3 cycles returning 0x12345678 → 3 cycles `readyout`=0, then 1 with `ahb_rdata_out`=0x12345678, `other_strb_out`=4'hC.
- Misaligned read 0x1001 size 2; separately size 3 with 32-bit data → no `other_valid_out`; resp=1/readyout=0 then resp=1/readyout=1.
- Backend error: write, `other_ready_in`=1 with `other_error_in`=1 → two-cycle ERROR; NONSEQ accepted in ERR2 is serviced normally.
- Timeout: WAIT_TIMEOUT=4, backend never ready → `readyout`=0 for 3 cycles, then a two-cycle ERROR, `other_valid_out` deasserts.
- Four pipelined SEQ reads with a zero-wait backend, then reset asserted mid-burst → 4 completions in 4 cycles; on reset all outputs at their reset values immediately.
